fpu_rr_arbiter: RTL and testbench

- Shares one FPU instance between NUM_REQ requester ports (cores or APU interconnect masters).
- Issue path: round-robin arbitration with grant lock under stall. Response path: results are routed back to the issuing port by a requester ID carried in the FPU tag.
- Bounds total in-flight operations with an occupancy counter.
- Sits between the requester ports and the FPU wrapper's downstream valid/ready and upstream req/ack handshakes.

---
 rtl/fpu_rr_arbiter_pkg.sv | 29 ++
 rtl/fpu_rr_arbiter_if.sv | 57 +++++
 rtl/fpu_rr_arbiter_rr_prio_sel.sv | 32 +++
 rtl/fpu_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_fpu_rr_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/fpu_rr_arbiter_pkg.sv
// Shared constants, request payload type and pointer helper for the FPU
// round-robin arbiter.
package fpu_rr_arbiter_pkg;

    localparam int unsigned NUM_REQ      = 4;
    localparam int unsigned ID_W         = $clog2(NUM_REQ);
    localparam int unsigned TAG_W        = 4;
    localparam int unsigned FTAG_W       = ID_W + TAG_W;
    localparam int unsigned MAX_INFLIGHT = 4;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned C_OP         = 32;
    localparam int unsigned C_CMD        = 4;
    localparam int unsigned C_RM         = 3;
    localparam int unsigned C_FLAG       = 9;

    typedef struct packed {
        logic [C_OP-1:0]  opa;
        logic [C_OP-1:0]  opb;
        logic [C_CMD-1:0] op;
        logic [C_RM-1:0]  rm;
        logic [TAG_W-1:0] tag;
    } fpu_req_t;

    // Port after id, wrapping to 0 past the last requester.
    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
    endfunction

endpackage

// File: rtl/fpu_rr_arbiter_if.sv
// Requester-side and FPU-side handshake bundle of the arbiter.
// slave: arbiter view; master: requesters plus FPU wrapper view.
interface fpu_rr_arbiter_if
    import fpu_rr_arbiter_pkg::*;
();

    logic [NUM_REQ-1:0]             Req_Valid_SI;
    logic [NUM_REQ-1:0]             Req_Ready_SO;
    logic [NUM_REQ-1:0][C_OP-1:0]   Req_OpA_DI;
    logic [NUM_REQ-1:0][C_OP-1:0]   Req_OpB_DI;
    logic [NUM_REQ-1:0][C_CMD-1:0]  Req_Op_SI;
    logic [NUM_REQ-1:0][C_RM-1:0]   Req_RM_SI;
    logic [NUM_REQ-1:0][TAG_W-1:0]  Req_Tag_DI;

    logic                           Fpu_Valid_SO;
    logic                           Fpu_Ready_SI;
    logic [C_OP-1:0]                Fpu_OpA_DO;
    logic [C_OP-1:0]                Fpu_OpB_DO;
    logic [C_CMD-1:0]               Fpu_Op_SO;
    logic [C_RM-1:0]                Fpu_RM_SO;
    logic [FTAG_W-1:0]              Fpu_Tag_DO;

    logic                           Fpu_Req_SI;
    logic [FTAG_W-1:0]              Fpu_Tag_DI;
    logic [C_OP-1:0]                Fpu_Result_DI;
    logic [C_FLAG-1:0]              Fpu_Flags_DI;
    logic                           Fpu_Ack_SO;

    logic [NUM_REQ-1:0]             Resp_Valid_SO;
    logic [NUM_REQ-1:0]             Resp_Ack_SI;
    logic [C_OP-1:0]                Resp_Result_DO;
    logic [C_FLAG-1:0]              Resp_Flags_DO;
    logic [TAG_W-1:0]               Resp_Tag_DO;

    modport slave (
        input  Req_Valid_SI, Req_OpA_DI, Req_OpB_DI, Req_Op_SI, Req_RM_SI, Req_Tag_DI,
        output Req_Ready_SO,
        output Fpu_Valid_SO, Fpu_OpA_DO, Fpu_OpB_DO, Fpu_Op_SO, Fpu_RM_SO, Fpu_Tag_DO,
        input  Fpu_Ready_SI,
        input  Fpu_Req_SI, Fpu_Tag_DI, Fpu_Result_DI, Fpu_Flags_DI,
        output Fpu_Ack_SO,
        output Resp_Valid_SO, Resp_Result_DO, Resp_Flags_DO, Resp_Tag_DO,
        input  Resp_Ack_SI
    );

    modport master (
        output Req_Valid_SI, Req_OpA_DI, Req_OpB_DI, Req_Op_SI, Req_RM_SI, Req_Tag_DI,
        input  Req_Ready_SO,
        input  Fpu_Valid_SO, Fpu_OpA_DO, Fpu_OpB_DO, Fpu_Op_SO, Fpu_RM_SO, Fpu_Tag_DO,
        output Fpu_Ready_SI,
        output Fpu_Req_SI, Fpu_Tag_DI, Fpu_Result_DI, Fpu_Flags_DI,
        input  Fpu_Ack_SO,
        input  Resp_Valid_SO, Resp_Result_DO, Resp_Flags_DO, Resp_Tag_DO,
        output Resp_Ack_SI
    );

endinterface

// File: rtl/fpu_rr_arbiter_rr_prio_sel.sv
// Round-robin first-one finder: first set bit of valid_i scanning upward
// from ptr_i and wrapping modulo NUM_REQ.
module rr_prio_sel
    import fpu_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [ID_W-1:0]    grant_o,
    output logic               found_o
);

    localparam int unsigned IDX_W = ID_W + 1;

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr_i} + IDX_W'(i);
            if (idx >= IDX_W'(NUM_REQ)) begin
                idx = idx - IDX_W'(NUM_REQ);
            end
            if (!found_o && valid_i[idx[ID_W-1:0]]) begin
                found_o = 1'b1;
                grant_o = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fpu_rr_arbiter.sv
// Shares one FPU between NUM_REQ requesters: round-robin issue with grant
// lock under stall, tag-routed responses, bounded in-flight count.
module fpu_rr_arbiter
    import fpu_rr_arbiter_pkg::*;
(
    input  logic            Clk_CI,
    input  logic            Rst_RI,
    fpu_rr_arbiter_if.slave bus
);

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [ID_W-1:0]  lock_id_q, lock_id_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;

    logic [ID_W-1:0]  rr_grant;
    logic             rr_found;
    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  resp_id;
    logic             can_issue;
    logic             fpu_valid;
    logic             fire;
    logic             resp_drop;
    logic             fpu_ack;
    logic             resp_done;
    fpu_req_t         req_arr [NUM_REQ];
    fpu_req_t         sel_req;

    rr_prio_sel u_rr_prio_sel (
        .valid_i (bus.Req_Valid_SI),
        .ptr_i   (rr_ptr_q),
        .grant_o (rr_grant),
        .found_o (rr_found)
    );

    always_comb begin
        for (int unsigned p = 0; p < NUM_REQ; p++) begin
            req_arr[p] = '{opa: bus.Req_OpA_DI[p], opb: bus.Req_OpB_DI[p],
                           op:  bus.Req_Op_SI[p],  rm:  bus.Req_RM_SI[p],
                           tag: bus.Req_Tag_DI[p]};
        end
    end

    always_comb begin
        rr_ptr_d           = rr_ptr_q;
        lock_d             = lock_q;
        lock_id_d          = lock_id_q;
        inflight_d         = inflight_q;
        bus.Req_Ready_SO   = '0;
        bus.Resp_Valid_SO  = '0;

        can_issue = inflight_q < CNT_W'(MAX_INFLIGHT);
        grant     = lock_q ? lock_id_q : rr_grant;
        fpu_valid = !Rst_RI && can_issue
                    && (lock_q ? bus.Req_Valid_SI[lock_id_q] : rr_found);
        fire      = fpu_valid && bus.Fpu_Ready_SI;
        sel_req   = req_arr[grant];

        // With nothing outstanding a returning result is stale: ack and drop it.
        resp_id   = bus.Fpu_Tag_DI[FTAG_W-1 -: ID_W];
        resp_drop = (inflight_q == '0);
        fpu_ack   = !Rst_RI && (resp_drop || bus.Resp_Ack_SI[resp_id]);
        resp_done = bus.Fpu_Req_SI && fpu_ack && !resp_drop;

        if (fire) begin
            bus.Req_Ready_SO[grant] = 1'b1;
        end
        if (!Rst_RI && bus.Fpu_Req_SI && !resp_drop) begin
            bus.Resp_Valid_SO[resp_id] = 1'b1;
        end

        if (fire) begin
            rr_ptr_d = rr_next(grant);
            lock_d   = 1'b0;
        end else if (fpu_valid) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end

        if (fire && !resp_done) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (resp_done && !fire) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    assign bus.Fpu_Valid_SO   = fpu_valid;
    assign bus.Fpu_OpA_DO     = sel_req.opa;
    assign bus.Fpu_OpB_DO     = sel_req.opb;
    assign bus.Fpu_Op_SO      = sel_req.op;
    assign bus.Fpu_RM_SO      = sel_req.rm;
    assign bus.Fpu_Tag_DO     = {grant, sel_req.tag};
    assign bus.Fpu_Ack_SO     = fpu_ack;
    assign bus.Resp_Result_DO = bus.Fpu_Result_DI;
    assign bus.Resp_Flags_DO  = bus.Fpu_Flags_DI;
    assign bus.Resp_Tag_DO    = bus.Fpu_Tag_DI[TAG_W-1:0];

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_id_q  <= '0;
            inflight_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_id_q  <= lock_id_d;
            inflight_q <= inflight_d;
        end
    end

    // Requester must hold valid while locked; counter stays within bounds.
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RI) begin
            a_lock_hold: assert (!lock_q || bus.Req_Valid_SI[lock_id_q]);
            a_inflight_max: assert (inflight_q <= CNT_W'(MAX_INFLIGHT));
            a_no_underflow: assert (!(resp_done && !fire && inflight_q == '0));
        end
    end

endmodule

// File: tb/tb_fpu_rr_arbiter.sv
// Directed bench for fpu_rr_arbiter: reset, round-robin order, stall lock,
// credit limit, response routing and stale-response drop after reset.
module tb_fpu_rr_arbiter;
    import fpu_rr_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   fires;

    fpu_rr_arbiter_if bus_if ();

    fpu_rr_arbiter dut (
        .Clk_CI (clk),
        .Rst_RI (rst),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic count_fires(input int cycles);
        fires = 0;
        for (int c = 0; c < cycles; c++) begin
            #1;
            if (bus_if.Fpu_Valid_SO && bus_if.Fpu_Ready_SI) fires++;
            tick();
        end
    endtask

    initial begin
        logic [3:0] exp_v;
        total = 0;
        bad   = 0;
        fires = 0;
        rst   = 1'b1;
        for (int p = 0; p < NUM_REQ; p++) begin
            bus_if.Req_OpA_DI[p] = 32'h1000_0000 + 32'(p);
            bus_if.Req_OpB_DI[p] = 32'h2000_0000 + 32'(p);
            bus_if.Req_Op_SI[p]  = C_CMD'(p);
            bus_if.Req_RM_SI[p]  = C_RM'(p);
            bus_if.Req_Tag_DI[p] = TAG_W'(5 + p);
        end
        bus_if.Req_Valid_SI  = 4'b1111;
        bus_if.Fpu_Ready_SI  = 1'b1;
        bus_if.Fpu_Req_SI    = 1'b1;
        bus_if.Fpu_Tag_DI    = 6'h00;
        bus_if.Fpu_Result_DI = 32'h0;
        bus_if.Fpu_Flags_DI  = 9'h0;
        bus_if.Resp_Ack_SI   = 4'b1111;

        // Reset held for 3 cycles: every handshake output low
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("rst_fpu_valid", 32'(bus_if.Fpu_Valid_SO), 32'h0);
            chk("rst_req_ready", 32'(bus_if.Req_Ready_SO), 32'h0);
            chk("rst_fpu_ack", 32'(bus_if.Fpu_Ack_SO), 32'h0);
            chk("rst_resp_valid", 32'(bus_if.Resp_Valid_SO), 32'h0);
            tick();
        end
        rst = 1'b0;
        bus_if.Fpu_Req_SI  = 1'b0;
        bus_if.Resp_Ack_SI = 4'b0000;

        // Round-robin order 0,1,2,3 then full at 4 in flight
        #1;
        chk("rr0_valid", 32'(bus_if.Fpu_Valid_SO), 32'h1);
        chk("rr0_ready", 32'(bus_if.Req_Ready_SO), 32'h1);
        chk("rr0_tag", 32'(bus_if.Fpu_Tag_DO), 32'h05);
        chk("rr0_opa", bus_if.Fpu_OpA_DO, 32'h1000_0000);
        tick();
        chk("rr1_ready", 32'(bus_if.Req_Ready_SO), 32'h2);
        chk("rr1_tag", 32'(bus_if.Fpu_Tag_DO), 32'h16);
        tick();
        chk("rr2_ready", 32'(bus_if.Req_Ready_SO), 32'h4);
        chk("rr2_tag", 32'(bus_if.Fpu_Tag_DO), 32'h27);
        chk("rr2_opb", bus_if.Fpu_OpB_DO, 32'h2000_0002);
        tick();
        chk("rr3_ready", 32'(bus_if.Req_Ready_SO), 32'h8);
        chk("rr3_tag", 32'(bus_if.Fpu_Tag_DO), 32'h38);
        tick();
        chk("full_valid", 32'(bus_if.Fpu_Valid_SO), 32'h0);
        chk("full_ready", 32'(bus_if.Req_Ready_SO), 32'h0);

        // Routing: id 3 not acked -> held, then acked
        bus_if.Req_Valid_SI  = 4'b0000;
        bus_if.Fpu_Req_SI    = 1'b1;
        bus_if.Fpu_Tag_DI    = 6'h3A;
        bus_if.Fpu_Result_DI = 32'hCAFE_0003;
        bus_if.Fpu_Flags_DI  = 9'h155;
        bus_if.Resp_Ack_SI   = 4'b0111;
        #1;
        chk("route_valid", 32'(bus_if.Resp_Valid_SO), 32'h8);
        chk("route_noack", 32'(bus_if.Fpu_Ack_SO), 32'h0);
        chk("route_tag", 32'(bus_if.Resp_Tag_DO), 32'hA);
        chk("route_result", bus_if.Resp_Result_DO, 32'hCAFE_0003);
        chk("route_flags", 32'(bus_if.Resp_Flags_DO), 32'h155);
        tick();
        bus_if.Resp_Ack_SI = 4'b1000;
        #1;
        chk("route_hold_valid", 32'(bus_if.Resp_Valid_SO), 32'h8);
        chk("route_ack", 32'(bus_if.Fpu_Ack_SO), 32'h1);
        tick();
        bus_if.Resp_Ack_SI = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            bus_if.Fpu_Tag_DI = {2'(k), 4'h0};
            exp_v = 4'b0001 << k;
            #1;
            chk("drain_valid", 32'(bus_if.Resp_Valid_SO), 32'(exp_v));
            chk("drain_ack", 32'(bus_if.Fpu_Ack_SO), 32'h1);
            tick();
        end
        bus_if.Fpu_Req_SI  = 1'b0;
        bus_if.Resp_Ack_SI = 4'b0000;

        // Stall lock on port 2 while port 1 joins
        bus_if.Req_Valid_SI = 4'b0100;
        bus_if.Fpu_Ready_SI = 1'b0;
        #1;
        chk("stall_valid", 32'(bus_if.Fpu_Valid_SO), 32'h1);
        chk("stall_ready", 32'(bus_if.Req_Ready_SO), 32'h0);
        tick();
        bus_if.Req_Valid_SI = 4'b0110;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("lock_id", 32'(bus_if.Fpu_Tag_DO[5:4]), 32'h2);
            chk("lock_ready", 32'(bus_if.Req_Ready_SO), 32'h0);
            tick();
        end
        bus_if.Fpu_Ready_SI = 1'b1;
        #1;
        chk("lock_fire_ready", 32'(bus_if.Req_Ready_SO), 32'h4);
        chk("lock_fire_opa", bus_if.Fpu_OpA_DO, 32'h1000_0002);
        tick();
        bus_if.Req_Valid_SI = 4'b0010;
        #1;
        chk("after_lock_id", 32'(bus_if.Fpu_Tag_DO[5:4]), 32'h1);
        chk("after_lock_ready", 32'(bus_if.Req_Ready_SO), 32'h2);
        tick();

        // Fire and response together at 2 in flight: count stays 2
        bus_if.Req_Valid_SI = 4'b0001;
        bus_if.Fpu_Req_SI   = 1'b1;
        bus_if.Fpu_Tag_DI   = 6'h03;
        bus_if.Resp_Ack_SI  = 4'b0001;
        #1;
        chk("both_ready", 32'(bus_if.Req_Ready_SO), 32'h1);
        chk("both_ack", 32'(bus_if.Fpu_Ack_SO), 32'h1);
        tick();
        bus_if.Fpu_Req_SI = 1'b0;
        count_fires(4);
        chk("credit_fill", 32'(fires), 32'd2);
        chk("credit_full_valid", 32'(bus_if.Fpu_Valid_SO), 32'h0);

        // Response at full does not open issue in the same cycle
        bus_if.Fpu_Req_SI = 1'b1;
        bus_if.Fpu_Tag_DI = 6'h01;
        #1;
        chk("full_resp_valid", 32'(bus_if.Fpu_Valid_SO), 32'h0);
        chk("full_resp_ack", 32'(bus_if.Fpu_Ack_SO), 32'h1);
        tick();
        bus_if.Fpu_Req_SI = 1'b0;
        count_fires(3);
        chk("one_more_fire", 32'(fires), 32'd1);

        // Retire one, leaving 3 outstanding, then pulse reset
        bus_if.Req_Valid_SI = 4'b0000;
        bus_if.Fpu_Req_SI   = 1'b1;
        bus_if.Fpu_Tag_DI   = 6'h02;
        #1;
        chk("retire_valid", 32'(bus_if.Resp_Valid_SO), 32'h1);
        tick();
        rst = 1'b1;
        bus_if.Fpu_Tag_DI  = 6'h10;
        bus_if.Resp_Ack_SI = 4'b1111;
        #1;
        chk("midrst_ack", 32'(bus_if.Fpu_Ack_SO), 32'h0);
        chk("midrst_resp", 32'(bus_if.Resp_Valid_SO), 32'h0);
        tick();
        rst = 1'b0;
        bus_if.Resp_Ack_SI = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            bus_if.Fpu_Tag_DI = {2'(k + 1), 4'(k)};
            #1;
            chk("stale_ack", 32'(bus_if.Fpu_Ack_SO), 32'h1);
            chk("stale_resp", 32'(bus_if.Resp_Valid_SO), 32'h0);
            tick();
        end
        bus_if.Fpu_Req_SI   = 1'b0;
        bus_if.Req_Valid_SI = 4'b0001;
        count_fires(6);
        chk("post_rst_credit", 32'(fires), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
